sram_port_arbiter: RTL and testbench

Arbitrates the single-ported external SRAM between the instruction-fetch requester and the memory-stage data requester of the 5-stage MIPS core. Each granted access runs a fixed-length SRAM cycle. The block returns a one-cycle acknowledge with registered read data and raises per-stage stall requests to the pipeline control while an access is outstanding. The MEM→WB and IF→ID pipeline registers only advance when their stage's stall request is low.

---
 rtl/sram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares the single-ported external SRAM between instruction fetch and the
// memory stage; fixed-length accesses, one-cycle acks, per-stage stall requests.
module sram_port_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic              stall_req_if,
  output logic              stall_req_mem,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_ACC = 2'd1, MEM_ACC = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       last_grant;
  logic       flush_seen;
  logic       if_elig, mem_elig;
  logic       grant_if, grant_mem, access_done;

  assign stall_req_if  = if_req & ~if_ack;
  assign stall_req_mem = mem_req & ~mem_ack;

  // A requester in its ack cycle is not eligible, so a held req is never re-granted;
  // under contention the side that did not win last time is preferred.
  always_comb begin
    if_elig     = if_req & ~if_ack & ~flush;
    mem_elig    = mem_req & ~mem_ack;
    grant_if    = 1'b0;
    grant_mem   = 1'b0;
    access_done = 1'b0;
    state_next  = state;
    case (state)
      IDLE: begin
        if (mem_elig && (!if_elig || !last_grant)) begin
          grant_mem  = 1'b1;
          state_next = MEM_ACC;
        end else if (if_elig) begin
          grant_if   = 1'b1;
          state_next = IF_ACC;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (cnt == 4'd0) begin
          access_done = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  // A flush seen in any IF_ACC cycle (including the last) drops the fetch result.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt        <= 4'd0;
      last_grant <= 1'b0;
      flush_seen <= 1'b0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= 32'd0;
      mem_rdata  <= 32'd0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= 4'd0;
      sram_addr  <= '0;
      sram_wdata <= 32'd0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      if (grant_if) begin
        sram_ce    <= 1'b1;
        sram_we    <= 1'b0;
        sram_be    <= 4'hF;
        sram_addr  <= if_addr;
        cnt        <= CNT_LOAD;
        last_grant <= 1'b0;
      end else if (grant_mem) begin
        sram_ce    <= 1'b1;
        sram_we    <= mem_we;
        sram_be    <= mem_be;
        sram_addr  <= mem_addr;
        sram_wdata <= mem_wdata;
        cnt        <= CNT_LOAD;
        last_grant <= 1'b1;
      end else if (access_done) begin
        sram_ce    <= 1'b0;
        sram_we    <= 1'b0;
        sram_be    <= 4'd0;
        flush_seen <= 1'b0;
        if (state == IF_ACC) begin
          if (!(flush_seen || flush)) begin
            if_ack   <= 1'b1;
            if_rdata <= sram_rdata;
          end
        end else begin
          mem_ack <= 1'b1;
          if (!sram_we) mem_rdata <= sram_rdata;
        end
      end else if (state != IDLE) begin
        cnt <= cnt - 4'd1;
        if (state == IF_ACC && flush) flush_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, corner sequences and
// randomized traffic checked against a transaction-level shadow memory.
module tb_sram_port_arbiter;

  localparam int ADDR_W = 20;
  localparam int AC     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, flush;
  logic              if_req, if_ack, mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] if_addr, mem_addr, sram_addr;
  logic [31:0]       if_rdata, mem_rdata, mem_wdata, sram_wdata, sram_rdata;
  logic [3:0]        mem_be, sram_be;
  logic              stall_req_if, stall_req_mem, sram_ce, sram_we;

  logic              flush_1, if_req_1, if_ack_1, mem_req_1, mem_we_1, mem_ack_1;
  logic [ADDR_W-1:0] if_addr_1, mem_addr_1, sram_addr_1;
  logic [31:0]       if_rdata_1, mem_rdata_1, mem_wdata_1, sram_wdata_1, sram_rdata_1;
  logic [3:0]        mem_be_1, sram_be_1;
  logic              stall_req_if_1, stall_req_mem_1, sram_ce_1, sram_we_1;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_port_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(1)) dut_1 (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .flush(flush_1),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_ack(if_ack_1), .if_rdata(if_rdata_1),
    .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_be(mem_be_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_ack(mem_ack_1), .mem_rdata(mem_rdata_1),
    .stall_req_if(stall_req_if_1), .stall_req_mem(stall_req_mem_1),
    .sram_ce(sram_ce_1), .sram_we(sram_we_1), .sram_be(sram_be_1), .sram_addr(sram_addr_1),
    .sram_wdata(sram_wdata_1), .sram_rdata(sram_rdata_1)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] sram_arr [logic [ADDR_W-1:0]];
  logic [31:0] shadow   [logic [ADDR_W-1:0]];

  function automatic logic [31:0] default_word(logic [ADDR_W-1:0] a);
    return {12'hC0D, a};
  endfunction

  function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sram_read(logic [ADDR_W-1:0] a);
    return sram_arr.exists(a) ? sram_arr[a] : default_word(a);
  endfunction

  function automatic logic [31:0] shadow_read(logic [ADDR_W-1:0] a);
    return shadow.exists(a) ? shadow[a] : default_word(a);
  endfunction

  // SRAM devices: writes land while strobed, read data presented mid-cycle.
  always @(negedge clk) begin
    if (sram_ce && sram_we) sram_arr[sram_addr] = merge_bytes(sram_read(sram_addr), sram_wdata, sram_be);
    sram_rdata   = (sram_ce && !sram_we) ? sram_read(sram_addr) : 32'd0;
    sram_rdata_1 = sram_ce_1 ? default_word(sram_addr_1) : 32'd0;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic              is_mem;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic apply_stimulus(input vec_t v);
    bit acked;
    int ce_cycles;
    logic ack, stall;
    acked = 0;
    ce_cycles = 0;
    @(negedge clk);
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_be = v.be; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    check_output("stall_on_request", v.is_mem ? stall_req_mem : stall_req_if, 1);
    for (int n = 1; n <= 12 && !acked; n++) begin
      @(negedge clk);
      ack   = v.is_mem ? mem_ack : if_ack;
      stall = v.is_mem ? stall_req_mem : stall_req_if;
      if (sram_ce) begin
        ce_cycles++;
        check_output("sram_we", sram_we, v.is_mem & v.we);
        check_output("sram_be", sram_be, v.is_mem ? v.be : 4'hF);
        check_output("sram_addr", sram_addr, v.addr);
        if (v.is_mem && v.we) check_output("sram_wdata", sram_wdata, v.wdata);
      end
      check_output("stall_level", stall, !ack);
      if (ack) begin
        acked = 1;
        check_output("ack_latency", n, AC + 1);
        check_output("rdata", v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
        if (v.is_mem) begin
          mem_req = 1'b0;
          if (v.we) shadow[v.addr] = merge_bytes(shadow_read(v.addr), v.wdata, v.be);
        end else begin
          if_req = 1'b0;
        end
      end
    end
    if (!acked) begin
      check_output("ack_timeout", 0, 1);
      mem_req = 1'b0;
      if_req  = 1'b0;
    end
    check_output("ce_cycles", ce_cycles, AC);
  endtask

  task automatic random_if(input int count);
    logic [ADDR_W-1:0] a;
    bit got;
    for (int t = 0; t < count; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      a = ADDR_W'($urandom_range(0, 7));
      if_addr = a;
      if_req  = 1'b1;
      got = 0;
      for (int n = 1; n <= 8 && !got; n++) begin
        @(negedge clk);
        check_output("rand_stall_if", stall_req_if, if_req & ~if_ack);
        if (if_ack) begin
          got = 1;
          check_output("rand_if_rdata", if_rdata, shadow_read(a));
          if_req = 1'b0;
        end
      end
      if (!got) begin
        check_output("rand_if_timeout", 0, 1);
        if_req = 1'b0;
      end
    end
  endtask

  task automatic random_mem(input int count);
    logic [ADDR_W-1:0] a;
    logic [31:0] wd;
    logic [3:0] be;
    logic we;
    bit got;
    for (int t = 0; t < count; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      a  = ADDR_W'($urandom_range(0, 7));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      we = 1'($urandom_range(0, 1));
      mem_addr = a; mem_wdata = wd; mem_be = be; mem_we = we;
      mem_req  = 1'b1;
      got = 0;
      for (int n = 1; n <= 8 && !got; n++) begin
        @(negedge clk);
        check_output("rand_stall_mem", stall_req_mem, mem_req & ~mem_ack);
        if (mem_ack) begin
          got = 1;
          if (we) shadow[a] = merge_bytes(shadow_read(a), wd, be);
          else    check_output("rand_mem_rdata", mem_rdata, shadow_read(a));
          mem_req = 1'b0;
        end
      end
      if (!got) begin
        check_output("rand_mem_timeout", 0, 1);
        mem_req = 1'b0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, last_n;
    bit seen;
    logic [31:0] exp_data;

    vecs[0] = '{1'b0, 1'b0, 4'h0,    20'h00100, 32'h0,         32'h2402_0005};
    vecs[1] = '{1'b1, 1'b1, 4'b0011, 20'h00040, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 4'hF,    20'h00040, 32'h0,         32'hC0D0_BEEF};
    vecs[3] = '{1'b0, 1'b0, 4'h0,    20'h00040, 32'h0,         32'hC0D0_BEEF};
    vecs[4] = '{1'b1, 1'b1, 4'b1100, 20'h00040, 32'h1234_5678, 32'hC0D0_BEEF};
    vecs[5] = '{1'b1, 1'b0, 4'hF,    20'h00040, 32'h0,         32'h1234_BEEF};
    vecs[6] = '{1'b1, 1'b1, 4'hF,    20'h00007, 32'hCAFE_F00D, 32'h1234_BEEF};
    vecs[7] = '{1'b0, 1'b0, 4'h0,    20'h00007, 32'h0,         32'hCAFE_F00D};

    sram_arr[20'h00100] = 32'h2402_0005;
    shadow[20'h00100]   = 32'h2402_0005;

    rst_n = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_be = 4'd0;
    mem_addr = '0; mem_wdata = 32'd0;
    flush_1 = 1'b0; if_req_1 = 1'b0; if_addr_1 = '0; mem_req_1 = 1'b0; mem_we_1 = 1'b0;
    mem_be_1 = 4'hF; mem_addr_1 = '0; mem_wdata_1 = 32'd0;

    repeat (2) @(negedge clk);
    check_output("reset_sram_ce", sram_ce, 0);
    check_output("reset_sram_we", sram_we, 0);
    check_output("reset_sram_be", sram_be, 0);
    check_output("reset_sram_addr", sram_addr, 0);
    check_output("reset_acks", {if_ack, mem_ack}, 0);
    check_output("reset_if_rdata", if_rdata, 0);
    check_output("reset_mem_rdata", mem_rdata, 0);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    $display("[TB] contention with both requests held");
    @(negedge clk);
    if_req = 1'b1; if_addr = 20'h00100;
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 20'h00040;
    k = 0; last_n = 0;
    for (int n = 1; n <= 30 && k < 6; n++) begin
      @(negedge clk);
      if (mem_ack || if_ack) begin
        check_output("contention_order_mem", mem_ack, (k % 2) == 0);
        check_output("contention_order_if", if_ack, (k % 2) == 1);
        check_output("contention_spacing", n - last_n, AC + 1);
        if (mem_ack) check_output("contention_mem_rdata", mem_rdata, 32'h1234_BEEF);
        if (if_ack)  check_output("contention_if_rdata", if_rdata, 32'h2402_0005);
        last_n = n;
        k++;
      end
    end
    if (k < 6) check_output("contention_timeout", k, 6);
    if_req = 1'b0; mem_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] flush in final IF_ACC cycle");
    @(negedge clk);
    if_req = 1'b1; if_addr = 20'h00007;
    @(negedge clk);
    @(negedge clk);
    check_output("flush_access_runs", sram_ce, 1);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      seen |= if_ack;
      @(negedge clk);
    end
    check_output("flush_no_ack", seen, 0);
    check_output("flush_rdata_held", if_rdata, 32'h2402_0005);
    apply_stimulus(vecs[7]);

    $display("[TB] flush in first IF_ACC cycle only");
    @(negedge clk);
    if_req = 1'b1; if_addr = 20'h00040;
    @(negedge clk);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      seen |= if_ack;
      @(negedge clk);
    end
    check_output("sticky_flush_no_ack", seen, 0);
    check_output("sticky_flush_rdata", if_rdata, 32'hCAFE_F00D);

    $display("[TB] reset during MEM_ACC");
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 20'h00040;
    @(negedge clk);
    check_output("rst_mid_access_ce", sram_ce, 1);
    rst_n = 1'b0;
    #1;
    check_output("rst_async_ce", sram_ce, 0);
    check_output("rst_async_be", sram_be, 0);
    check_output("rst_async_addr", sram_addr, 0);
    check_output("rst_async_wdata", sram_wdata, 0);
    check_output("rst_async_rdata", {if_rdata, mem_rdata} == 64'd0, 1);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      seen |= mem_ack | sram_ce;
    end
    check_output("rst_idle_after", seen, 0);
    apply_stimulus(vecs[5]);

    $display("[TB] back-to-back reads with single-cycle access");
    for (int i = 0; i < 4; i++) begin
      bit got;
      int ce_cycles;
      @(negedge clk);
      mem_addr_1 = ADDR_W'(i + 1);
      mem_req_1  = 1'b1;
      got = 0; ce_cycles = 0;
      for (int n = 1; n <= 6 && !got; n++) begin
        @(negedge clk);
        if (sram_ce_1) ce_cycles++;
        if (mem_ack_1) begin
          got = 1;
          check_output("ac1_latency", n, 2);
          exp_data = default_word(ADDR_W'(i + 1));
          check_output("ac1_rdata", mem_rdata_1, exp_data);
          mem_req_1 = 1'b0;
        end
      end
      if (!got) begin
        check_output("ac1_timeout", 0, 1);
        mem_req_1 = 1'b0;
      end
      check_output("ac1_ce_cycles", ce_cycles, 1);
    end

    $display("[TB] randomized traffic");
    fork
      random_if(40);
      random_mem(40);
    join
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
